// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM main-memory arbiter: FSM state encoding
// and default port widths. Optional feature macro: MEM_ARB_FAIRNESS_EN.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int MAX_D_BURST_DEF = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

endpackage

// File: rtl/mem_arbiter_fair_counter.sv
// Saturating count of data grants made while a fetch is waiting. Once the
// count reaches MAX_D_BURST with a fetch pending, force_i tells the arbiter
// to serve the fetch next. Only instantiated under MEM_ARB_FAIRNESS_EN.
module arb_fair_counter #(
    parameter int MAX_D_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_d,
    input  logic grant_i,
    input  logic if_pending,
    output logic force_i
);

    localparam int CNT_W = $clog2(MAX_D_BURST + 1);

    logic [CNT_W-1:0] cnt;

    // Count data grants that starve a pending fetch; any fetch grant or an
    // uncontended data grant clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (grant_i) begin
            cnt <= '0;
        end else if (grant_d) begin
            if (!if_pending)
                cnt <= '0;
            else if (cnt != CNT_W'(MAX_D_BURST))
                cnt <= cnt + 1'b1;
        end
    end

    assign force_i = if_pending && (cnt == CNT_W'(MAX_D_BURST));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// load/store stage. Data has priority; with MEM_ARB_FAIRNESS_EN defined a
// waiting fetch is forced through after MAX_D_BURST consecutive data grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_D_BURST = MAX_D_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);

    state_t state;
    state_t state_next;
    logic   grant_d;
    logic   grant_i;
    logic   force_i;

    if (MAX_D_BURST < 1) begin : g_invalid_burst
        $error("MAX_D_BURST must be at least 1");
    end

`ifdef MEM_ARB_FAIRNESS_EN
    arb_fair_counter #(
        .MAX_D_BURST(MAX_D_BURST)
    ) u_fair (
        .clk       (clk),
        .rst       (rst),
        .grant_d   (grant_d),
        .grant_i   (grant_i),
        .if_pending(if_req),
        .force_i   (force_i)
    );
`else
    assign force_i = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and grant decode; requests are only sampled in IDLE.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && !force_i) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (if_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I:  if (mem_rvalid) state_next = RESP_I;
            BUSY_D:  if (mem_rvalid) state_next = RESP_D;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: latch the granted access, hold it until completion,
    // then capture read data and pulse ready during the RESP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
            busy      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            busy     <= (state_next != IDLE);
            if (grant_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end else if (grant_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
                mem_be   <= 4'hF;
            end
            if (state == BUSY_I && mem_rvalid) begin
                mem_req  <= 1'b0;
                if_rdata <= mem_rdata;
                if_ready <= 1'b1;
            end
            if (state == BUSY_D && mem_rvalid) begin
                mem_req <= 1'b0;
                d_ready <= 1'b1;
                // Stores leave the last load result visible.
                if (!mem_we)
                    d_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARB_FAIRNESS_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit fair_en;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        $display("check %-14s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MEM_ARB_FAIRNESS_EN
        fair_en = 1'b1;
`else
        fair_en = 1'b0;
`endif
        rst = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0; mem_rvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        tick();

        // Load to give d_rdata a known value.
        d_req = 1; d_we = 0; d_addr = 32'h3000; d_be = 4'hF;
        tick();
        check("ld_mem_req", {31'd0, mem_req}, 1);
        check("ld_mem_addr", mem_addr, 32'h3000);
        mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        check("ld_ready", {31'd0, d_ready}, 1);
        check("ld_rdata", d_rdata, 32'hCAFEF00D);
        check("ld_mem_req_lo", {31'd0, mem_req}, 0);
        d_req = 0; mem_rvalid = 0;
        tick();
        check("ld_ready_lo", {31'd0, d_ready}, 0);
        check("ld_busy_lo", {31'd0, busy}, 0);

        // Single fetch, memory answers one cycle after mem_req rises.
        if_req = 1; if_addr = 32'h100;
        tick();
        check("if_mem_req", {31'd0, mem_req}, 1);
        check("if_mem_addr", mem_addr, 32'h100);
        check("if_mem_we", {31'd0, mem_we}, 0);
        check("if_mem_be", {28'd0, mem_be}, 32'hF);
        check("if_busy", {31'd0, busy}, 1);
        tick();
        check("if_wait_req", {31'd0, mem_req}, 1);
        check("if_wait_rdy", {31'd0, if_ready}, 0);
        mem_rvalid = 1; mem_rdata = 32'h00500093;
        tick();
        check("if_ready", {31'd0, if_ready}, 1);
        check("if_rdata", if_rdata, 32'h00500093);
        mem_rvalid = 0; if_req = 0;
        tick();
        check("if_ready_lo", {31'd0, if_ready}, 0);

        // Store held for three wait cycles; d_rdata must not change.
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        tick();
        check("st_mem_we", {31'd0, mem_we}, 1);
        check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("st_mem_be", {28'd0, mem_be}, 32'h3);
        d_addr = 32'h5555; d_wdata = 32'h0; d_be = 4'hF;
        for (int w = 0; w < 3; w++) begin
            tick();
            check("st_hold_addr", mem_addr, 32'h2000);
            check("st_hold_wdata", mem_wdata, 32'hDEADBEEF);
            check("st_hold_req", {31'd0, mem_req}, 1);
        end
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        tick();
        check("st_ready", {31'd0, d_ready}, 1);
        check("st_rdata_keep", d_rdata, 32'hCAFEF00D);
        d_req = 0; d_we = 0; mem_rvalid = 0;
        tick();

        // Contention: data first, then fetch.
        if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h3004;
        tick();
        check("ct_d_addr", mem_addr, 32'h3004);
        mem_rvalid = 1; mem_rdata = 32'h11111111;
        tick();
        check("ct_d_ready", {30'd0, d_ready, if_ready}, 32'h2);
        check("ct_d_rdata", d_rdata, 32'h11111111);
        check("ct_gap_req", {31'd0, mem_req}, 0);
        d_req = 0; mem_rvalid = 0;
        tick();
        check("ct_idle_req", {31'd0, mem_req}, 0);
        tick();
        check("ct_i_addr", mem_addr, 32'h104);
        check("ct_i_req", {31'd0, mem_req}, 1);
        mem_rvalid = 1; mem_rdata = 32'h22222222;
        tick();
        check("ct_i_ready", {30'd0, d_ready, if_ready}, 32'h1);
        check("ct_i_rdata", if_rdata, 32'h22222222);
        if_req = 0; mem_rvalid = 0;
        tick();

        // Spurious completion while idle.
        mem_rvalid = 1; mem_rdata = 32'h99999999;
        tick();
        check("sp_ready", {30'd0, d_ready, if_ready}, 0);
        check("sp_busy", {31'd0, busy}, 0);
        check("sp_if_rdata", if_rdata, 32'h22222222);
        mem_rvalid = 0;

        // Fetch request dropped mid-access still completes.
        if_req = 1; if_addr = 32'h108;
        tick();
        check("ab_req", {31'd0, mem_req}, 1);
        if_req = 0;
        tick();
        check("ab_busy", {31'd0, busy}, 1);
        mem_rvalid = 1; mem_rdata = 32'h33333333;
        tick();
        check("ab_ready", {31'd0, if_ready}, 1);
        check("ab_rdata", if_rdata, 32'h33333333);
        mem_rvalid = 0;
        tick();
        check("ab_ready_lo", {31'd0, if_ready}, 0);
        check("ab_busy_lo", {31'd0, busy}, 0);

        // Both requests held: grant order depends on fairness.
        if_req = 1; if_addr = 32'h400; d_req = 1; d_we = 0; d_addr = 32'h800;
        for (int g = 0; g < 10; g++) begin
            logic is_i;
            is_i = fair_en && (g % 5 == 4);
            tick();
            check($sformatf("fr_grant%0d", g), mem_addr, is_i ? 32'h400 : 32'h800);
            mem_rvalid = 1; mem_rdata = 32'h1000 + g;
            tick();
            check($sformatf("fr_ready%0d", g), {30'd0, d_ready, if_ready}, is_i ? 32'h1 : 32'h2);
            mem_rvalid = 0;
            tick();
        end
        if_req = 0; d_req = 0;
        tick();

        // Asynchronous reset during a data access.
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hA5A5A5A5;
        tick();
        check("ar_req_pre", {31'd0, mem_req}, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_mem_req", {31'd0, mem_req}, 0);
        check("ar_busy", {31'd0, busy}, 0);
        check("ar_mem_addr", mem_addr, 0);
        check("ar_d_rdata", d_rdata, 0);
        d_req = 0; d_we = 0;
        #1 rst = 1'b1;
        tick();
        tick();
        check("ar_post_busy", {31'd0, busy}, 0);
        check("ar_post_ready", {30'd0, d_ready, if_ready}, 0);
        check("ar_post_req", {31'd0, mem_req}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
